font_rom_arbiter: RTL and testbench
===================================

FONT_ROM_ARBITER -- requirements
Module: font_rom_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 3, meaning the number of text-drawing requesters sharing one font_rom (2..8).
REQ-002 The block SHALL have parameter ADDR_W, default 11, meaning the font ROM address width as {char_code[6:0], char_line[3:0]}.
REQ-003 The block SHALL have parameter DATA_W, default 8, meaning the char_line_pixels width.
REQ-004 The block SHALL have parameter BURST_MAX, default 8, meaning the maximum consecutive grants to one requester before rotation (1..16).
REQ-005 The block SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, meaning the synchronous, active-high reset.
REQ-007 The block SHALL have port enable, input, 1, meaning the arbitration enable (driven by game_enable).
REQ-008 The block SHALL have port req, input, N_REQ, meaning the per-requester read request, held until granted.
REQ-009 The block SHALL have port addr, input, N_REQ*ADDR_W, meaning the per-requester ROM address; requester i uses slice [i*ADDR_W +: ADDR_W].
REQ-010 The block SHALL have port gnt, output, N_REQ, meaning the one-hot same-cycle grant.
REQ-011 The block SHALL have port rd_valid, output, N_REQ, meaning the one-hot read-data valid for the returning requester.
REQ-012 The block SHALL have port rd_data, output, DATA_W, meaning the read data shared by all requesters and qualified by rd_valid.
REQ-013 The block SHALL have port rom_addr, output, ADDR_W, meaning the registered address to the font ROM.
REQ-014 The block SHALL have port rom_data, input, DATA_W, meaning the font ROM output, valid one cycle after rom_addr.

Function
REQ-015 gnt SHALL be combinational from req, enable and internal state, with at most one bit set per cycle.
REQ-016 gnt SHALL be all-zero whenever enable=0 or rst=1.
REQ-017 A transfer SHALL occur in any cycle where gnt[i]=1; in that cycle req[i]=1 holds by construction.
REQ-018 Address path: at the end of the grant cycle t, rom_addr SHALL load addr slice i.
REQ-019 Return path: rom_data SHALL appear at t+2 with rd_valid[i]=1 and rd_data=rom_data. Latency is fixed at 2 cycles and fully pipelined, with one transfer possible per cycle.
REQ-020 rd_data SHALL be combinational pass-through of rom_data; rd_valid SHALL be a 2-stage registered shift of gnt.
REQ-021 rom_addr SHALL hold its previous value in cycles with no grant.
REQ-022 FSM state IDLE: grant the first requester with req=1, searching round-robin from pointer ptr upward modulo N_REQ. On any grant, go to BURST with owner=i and cnt=1.
REQ-023 FSM state BURST, owner keeps req=1 and cnt<BURST_MAX: gnt[owner]=1 and cnt increments.
REQ-024 FSM state BURST, owner keeps req=1 and cnt=BURST_MAX: ptr=owner+1 mod N_REQ and owner loses priority. In the same cycle, arbitrate as in IDLE excluding owner unless no other req is set. If owner is re-granted, cnt restarts at 1.
REQ-025 FSM state BURST, owner drops req: ptr=owner+1 mod N_REQ. In the same cycle, arbitrate as in IDLE (no bubble). If no req is set, go to IDLE.
REQ-026 enable falling to 0 in BURST SHALL force IDLE with ptr=owner+1 and cnt cleared.
REQ-027 Transfers already issued SHALL still complete their rd_valid when enable falls.
REQ-028 cnt SHALL be ceil(log2(BURST_MAX+1)) bits wide; ptr and owner SHALL be ceil(log2(N_REQ)) bits wide and wrap from N_REQ-1 to 0.
REQ-029 Requesters SHALL hold req and addr stable until gnt; addr may change in the cycle after gnt.

Reset
REQ-030 On rst=1 at a clock edge, the FSM SHALL go to IDLE with ptr=0, owner=0 and cnt=0.
REQ-031 On rst=1 at a clock edge, rom_addr SHALL be 0 and both rd_valid pipeline stages SHALL clear, discarding in-flight reads.
REQ-032 Reset during BURST SHALL abort the burst with no rd_valid in the following two cycles.

Verification
REQ-033 Single read: req=001, addr0=0x30A at t -> gnt=001 at t; rom_addr=0x30A at t+1; rd_valid=001 with rd_data=ROM[0x30A] at t+2.
REQ-034 Burst cap: N_REQ=3, BURST_MAX=8, req=011 held -> gnt0 for 8 cycles, then gnt1 for 8 cycles, then gnt0, with no idle cycle.
REQ-035 Round-robin wrap: ptr=2, req=101 -> gnt=100 first; after req2 drops, gnt=001 in the same cycle.
REQ-036 Enable drop mid-burst: enable=0 at cnt=3 -> gnt=0 that cycle; the last two rd_valid pulses still arrive. On enable=1, the next grant starts at owner+1.
REQ-037 Reset mid-pipeline: rst=1 one cycle after a grant -> rd_valid=0 for the next two cycles; rom_addr=0.
REQ-038 Lone requester: req=100 only, held 20 cycles -> gnt2 continuously, with cnt restarting after each 8 grants.

Source files
------------

// File: rtl/font_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous font ROM among N_REQ text requesters.
// Grants are combinational with a per-owner burst cap, and read data returns two cycles later.
module font_rom_arbiter #(
   parameter int unsigned N_REQ     = 3,
   parameter int unsigned ADDR_W    = 11,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned BURST_MAX = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*ADDR_W-1:0] addr,
   output logic [N_REQ-1:0]        gnt,
   output logic [N_REQ-1:0]        rd_valid,
   output logic [DATA_W-1:0]       rd_data,
   output logic [ADDR_W-1:0]       rom_addr,
   input  logic [DATA_W-1:0]       rom_data
);

   localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned CW = $clog2(BURST_MAX + 1);
   localparam logic [CW-1:0] CntMax  = CW'(BURST_MAX);
   localparam logic [PW-1:0] LastIdx = PW'(N_REQ - 1);

   typedef enum logic {StIdle, StBurst} state_e;

   state_e            state_q;
   logic [PW-1:0]     ptr_q;
   logic [PW-1:0]     owner_q;
   logic [CW-1:0]     cnt_q;
   logic [N_REQ-1:0]  vld1_q;
   logic [N_REQ-1:0]  vld2_q;

   logic [PW-1:0]     owner_nxt;
   logic [PW-1:0]     base;
   logic              hold;
   logic              pick_any;
   logic [PW-1:0]     pick_idx;
   logic [PW-1:0]     gnt_idx;
   logic              grant_on;
   logic [ADDR_W-1:0] sel_addr;

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
      return (v == LastIdx) ? '0 : v + PW'(1);
   endfunction

   // Searching from owner+1 puts the owner last, which covers both the burst-cap
   // rotation (owner only if nobody else) and the owner-dropped case.
   always_comb begin
      owner_nxt = wrap_inc(owner_q);
      hold      = (state_q == StBurst) && req[owner_q] && (cnt_q < CntMax);
      base      = (state_q == StBurst) ? owner_nxt : ptr_q;
      pick_any  = 1'b0;
      pick_idx  = '0;
      for (int k = 0; k < int'(N_REQ); k++) begin
         int            j;
         logic [PW-1:0] idx;
         j = int'(base) + k;
         if (j >= int'(N_REQ)) j = j - int'(N_REQ);
         idx = PW'(j);
         if (!pick_any && req[idx]) begin
            pick_any = 1'b1;
            pick_idx = idx;
         end
      end
      gnt_idx  = hold ? owner_q : pick_idx;
      grant_on = (hold || pick_any) && enable && !rst;
      gnt      = '0;
      sel_addr = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (grant_on && (gnt_idx == PW'(i))) begin
            gnt[i]   = 1'b1;
            sel_addr = addr[i*ADDR_W +: ADDR_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         ptr_q    <= '0;
         owner_q  <= '0;
         cnt_q    <= '0;
         rom_addr <= '0;
         vld1_q   <= '0;
         vld2_q   <= '0;
      end else begin
         vld1_q <= gnt;
         vld2_q <= vld1_q;
         if (grant_on) rom_addr <= sel_addr;

         if (!enable) begin
            if (state_q == StBurst) begin
               state_q <= StIdle;
               ptr_q   <= owner_nxt;
               cnt_q   <= '0;
            end
         end else if (grant_on) begin
            state_q <= StBurst;
            owner_q <= gnt_idx;
            cnt_q   <= hold ? cnt_q + CW'(1) : CW'(1);
            if (state_q == StBurst && !hold) ptr_q <= owner_nxt;
         end else if (state_q == StBurst) begin
            state_q <= StIdle;
            ptr_q   <= owner_nxt;
            cnt_q   <= '0;
         end
      end
   end

   assign rd_valid = vld2_q;
   assign rd_data  = rom_data;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Randomized bench for font_rom_arbiter against a cycle-level reference of the arbitration
// rules, with a behavioural synchronous ROM and directed burst/wrap/reset scenarios.
module tb_font_rom_arbiter;

   localparam int N  = 3;
   localparam int AW = 11;
   localparam int DW = 8;
   localparam int BM = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic [N-1:0]  req;
   logic [N*AW-1:0] addr;
   logic [N-1:0]  gnt;
   logic [N-1:0]  rd_valid;
   logic [DW-1:0] rd_data;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_data = '0;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference state: who was granted last, how many in a row, rotation pointer.
   int            m_active, m_last, m_streak, m_ptr;
   int            h1, h2;
   logic [AW-1:0] ha1, ha2, m_rom_addr;
   logic [N-1:0]  obs_gnt;
   int            last_eg;

   int            rem [N];
   logic [AW-1:0] cur_addr [N];

   always #5 clk = ~clk;

   font_rom_arbiter #(
      .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BM)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .req(req), .addr(addr),
      .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data),
      .rom_addr(rom_addr), .rom_data(rom_data)
   );

   function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
      logic [AW-1:0] t;
      t = a ^ (a >> 3);
      return t[DW-1:0] ^ 8'h5A;
   endfunction

   always @(posedge clk) rom_data <= rom_f(rom_addr);

   function automatic logic [N-1:0] oh(input int i);
      logic [N-1:0] v;
      v = '0;
      if (i >= 0) v[i] = 1'b1;
      return v;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   // One cycle: drive inputs, check outputs against the reference, advance the reference.
   task automatic step(input logic r, input logic e, input logic [N-1:0] rq,
                       input logic [N*AW-1:0] ad);
      int eg;
      int base;
      int j;
      logic [AW-1:0] ga;
      rst = r; enable = e; req = rq; addr = ad;
      #2;
      eg = -1;
      if (!r && e) begin
         if (m_active != 0 && rq[m_last] && m_streak < BM) eg = m_last;
         else begin
            base = (m_active != 0) ? (m_last + 1) % N : m_ptr;
            for (int k = 0; k < N; k++) begin
               j = (base + k) % N;
               if (eg < 0 && rq[j]) eg = j;
            end
         end
      end
      ga = (eg >= 0) ? ad[eg*AW +: AW] : '0;
      obs_gnt = gnt;
      check("gnt", 32'(gnt), 32'(oh(eg)));
      check("rd_valid", 32'(rd_valid), 32'(oh(h2)));
      if (h2 >= 0) check("rd_data", 32'(rd_data), 32'(rom_f(ha2)));
      check("rom_addr", 32'(rom_addr), 32'(m_rom_addr));

      if (r) begin
         m_active = 0; m_last = 0; m_streak = 0; m_ptr = 0;
         h1 = -1; h2 = -1; m_rom_addr = '0;
      end else begin
         h2 = h1; ha2 = ha1; h1 = eg; ha1 = ga;
         if (eg >= 0) m_rom_addr = ga;
         if (!e) begin
            if (m_active != 0) begin
               m_ptr = (m_last + 1) % N; m_active = 0; m_streak = 0;
            end
         end else if (eg >= 0) begin
            if (m_active != 0 && rq[m_last] && m_streak < BM) m_streak++;
            else begin
               if (m_active != 0) m_ptr = (m_last + 1) % N;
               m_streak = 1;
            end
            m_last = eg; m_active = 1;
         end else if (m_active != 0) begin
            m_ptr = (m_last + 1) % N; m_active = 0; m_streak = 0;
         end
      end
      last_eg = eg;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic rand_cycle(input logic r, input logic e);
      logic [N-1:0]    rq;
      logic [N*AW-1:0] ad;
      for (int i = 0; i < N; i++) begin
         if (rem[i] == 0 && $urandom_range(0, 3) == 0) begin
            rem[i]      = $urandom_range(1, 20);
            cur_addr[i] = AW'($urandom);
         end
         rq[i] = (rem[i] > 0);
         ad[i*AW +: AW] = cur_addr[i];
      end
      step(r, e, rq, ad);
      if (last_eg >= 0) begin
         rem[last_eg]--;
         cur_addr[last_eg] = AW'($urandom);
      end
   endtask

   initial begin
      int run0;
      int run1;
      logic [N*AW-1:0] a;
      rst = 1'b1; enable = 1'b0; req = '0; addr = '0;
      for (int i = 0; i < N; i++) begin rem[i] = 0; cur_addr[i] = '0; end
      @(posedge clk);
      #1;
      m_active = 0; m_last = 0; m_streak = 0; m_ptr = 0;
      h1 = -1; h2 = -1; ha1 = '0; ha2 = '0; m_rom_addr = '0;

      step(1'b1, 1'b1, 3'b111, '0);  // gnt must stay low during reset

      // Single read of 0x30A by requester 0
      a = '0; a[0 +: AW] = 11'h30A;
      step(1'b0, 1'b1, 3'b001, a);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'b000, a);

      // Lone requester 2 for 20 cycles, then release
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 3'b100, {11'(i), 22'h0});
      step(1'b0, 1'b1, 3'b000, '0);

      // Burst cap with req=011: expect eight grants each way
      run0 = 0; run1 = 0;
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, 3'b011, {11'h0, 11'(i + 100), 11'(i)});
         if (obs_gnt == 3'b001) run0++;
         if (obs_gnt == 3'b010) run1++;
      end
      check("burst_run0", 32'(run0), 32'd8);
      check("burst_run1", 32'(run1), 32'd8);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3'b011, {11'h0, 11'h55, 11'h66});

      // Wrap: rotate ptr to 2 via requester 1, then req=101
      step(1'b0, 1'b1, 3'b000, '0);
      step(1'b0, 1'b1, 3'b010, {11'h0, 11'h11, 11'h0});
      step(1'b0, 1'b1, 3'b000, '0);
      step(1'b0, 1'b1, 3'b101, {11'h7A0, 11'h0, 11'h0AB});
      step(1'b0, 1'b1, 3'b101, {11'h7A1, 11'h0, 11'h0AB});
      step(1'b0, 1'b1, 3'b001, {11'h0, 11'h0, 11'h0AB});

      // Enable drop mid-burst, then resume
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'b011, {11'h0, 11'h222, 11'(i + 1)});
      step(1'b0, 1'b0, 3'b011, {11'h0, 11'h222, 11'h3});
      step(1'b0, 1'b0, 3'b011, {11'h0, 11'h222, 11'h3});
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'b011, {11'h0, 11'(i + 300), 11'h3});

      // Reset one cycle after a grant
      step(1'b0, 1'b1, 3'b000, '0);
      step(1'b0, 1'b1, 3'b010, {11'h0, 11'h3FF, 11'h0});
      step(1'b1, 1'b1, 3'b010, {11'h0, 11'h3FF, 11'h0});
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'b000, '0);

      // Random traffic with occasional enable drops and resets
      for (int n = 0; n < 3000; n++)
         rand_cycle($urandom_range(0, 99) == 0, $urandom_range(0, 19) != 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
